// File: rtl/layer1_sched.sv
// +----------------------------------------------------------------------------+
// | layer1_sched : sequences NUM_NEURONS passes through one shared layer-1     |
// |                neuron datapath; optional argmax via LAYER1_SCHED_MAXIDX_EN |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module layer1_sched #(
  parameter int NUM_NEURONS = 32,
  parameter int IMAGE_SIZE  = 121,
  parameter int WEIGHT_BIT  = 4,
  parameter int OUTPUT_BIT  = 4,
  localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                             clk3,
  input  logic                             reset2,
  input  logic                             start,
  input  logic                             abort,
  input  logic [IMAGE_SIZE-1:0]            feat_in,
  input  logic [WEIGHT_BIT*IMAGE_SIZE-1:0] w_data,
  input  logic [2:0]                       b_data,
  input  logic [OUTPUT_BIT-1:0]            nrn_out,
  output logic                             w_rd,
  output logic [AW-1:0]                    w_addr,
  output logic [IMAGE_SIZE-1:0]            feat_out,
  output logic [WEIGHT_BIT*IMAGE_SIZE-1:0] weight_out,
  output logic [2:0]                       bias_out,
  output logic                             nrn_clr,
  output logic                             busy,
  output logic                             done,
  output logic [NUM_NEURONS*OUTPUT_BIT-1:0] result,
  output logic [AW-1:0]                    max_idx,
  output logic [OUTPUT_BIT-1:0]            max_val
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CLEAR = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [AW-1:0] c_K_LAST = AW'(NUM_NEURONS - 1);
  localparam logic [AW-1:0] c_K_ONE  = AW'(1);

  logic [2:0]                        r_state;
  logic [AW-1:0]                     r_k;
  logic [IMAGE_SIZE-1:0]             r_feat;
  logic [WEIGHT_BIT*IMAGE_SIZE-1:0]  r_weight;
  logic [2:0]                        r_bias;
  logic [NUM_NEURONS*OUTPUT_BIT-1:0] r_result;
  logic                              w_accept;
  logic                              w_store;

  assign w_accept = (r_state == S_IDLE) && start;
  // abort outranks the STORE write
  assign w_store  = (r_state == S_STORE) && !abort;

  always_ff @(posedge clk3 or negedge reset2) begin
    if (!reset2) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_feat   <= '0;
      r_weight <= '0;
      r_bias   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_feat   <= feat_in;
            r_result <= '0;
            r_k      <= '0;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: r_state <= abort ? S_IDLE : S_CLEAR;
        S_CLEAR: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_weight <= w_data;
            r_bias   <= b_data;
            r_state  <= S_EVAL;
          end
        end
        S_EVAL: r_state <= abort ? S_IDLE : S_STORE;
        S_STORE: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_result[r_k*OUTPUT_BIT +: OUTPUT_BIT] <= nrn_out;
            if (r_k == c_K_LAST) begin
              r_state <= S_DONE;
            end else begin
              r_k     <= r_k + c_K_ONE;
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LAYER1_SCHED_MAXIDX_EN
  logic [AW-1:0]         r_max_idx;
  logic [OUTPUT_BIT-1:0] r_max_val;

  // strict compare keeps the lowest index on ties
  always_ff @(posedge clk3 or negedge reset2) begin
    if (!reset2) begin
      r_max_idx <= '0;
      r_max_val <= '0;
    end else if (w_accept) begin
      r_max_idx <= '0;
      r_max_val <= '0;
    end else if (w_store && (nrn_out > r_max_val)) begin
      r_max_idx <= r_k;
      r_max_val <= nrn_out;
    end
  end

  assign max_idx = r_max_idx;
  assign max_val = r_max_val;
`else
  assign max_idx = '0;
  assign max_val = '0;
`endif

  assign w_rd       = (r_state == S_FETCH);
  assign nrn_clr    = (r_state == S_CLEAR);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign w_addr     = r_k;
  assign feat_out   = r_feat;
  assign weight_out = r_weight;
  assign bias_out   = r_bias;
  assign result     = r_result;

endmodule

`default_nettype wire

// File: tb/tb_layer1_sched.sv
// +----------------------------------------------------------------------------+
// | tb_layer1_sched : directed bench for layer1_sched with NUM_NEURONS=4       |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_layer1_sched;

  localparam int NN = 4;
  localparam int IS = 8;
  localparam int WB = 4;
  localparam int OB = 4;
  localparam int AW = 2;

  logic              clk3   = 1'b0;
  logic              reset2 = 1'b1;
  logic              start  = 1'b0;
  logic              abort  = 1'b0;
  logic [IS-1:0]     feat_in = '0;
  logic [WB*IS-1:0]  w_data  = '0;
  logic [2:0]        b_data  = '0;
  logic [OB-1:0]     nrn_out;
  logic              w_rd;
  logic [AW-1:0]     w_addr;
  logic [IS-1:0]     feat_out;
  logic [WB*IS-1:0]  weight_out;
  logic [2:0]        bias_out;
  logic              nrn_clr;
  logic              busy;
  logic              done;
  logic [NN*OB-1:0]  result;
  logic [AW-1:0]     max_idx;
  logic [OB-1:0]     max_val;

  logic [OB-1:0]     seq [NN];
  int                n_chk = 0;
  int                n_err = 0;

  layer1_sched #(
    .NUM_NEURONS(NN), .IMAGE_SIZE(IS), .WEIGHT_BIT(WB), .OUTPUT_BIT(OB)
  ) u_dut (
    .clk3(clk3), .reset2(reset2), .start(start), .abort(abort),
    .feat_in(feat_in), .w_data(w_data), .b_data(b_data), .nrn_out(nrn_out),
    .w_rd(w_rd), .w_addr(w_addr), .feat_out(feat_out), .weight_out(weight_out),
    .bias_out(bias_out), .nrn_clr(nrn_clr), .busy(busy), .done(done),
    .result(result), .max_idx(max_idx), .max_val(max_val)
  );

  always #5 clk3 = ~clk3;

  function automatic logic [WB*IS-1:0] rom_w(input logic [AW-1:0] k);
    return 32'h13579BDF ^ (32'h11111111 * {30'd0, k});
  endfunction

  function automatic logic [2:0] rom_b(input logic [AW-1:0] k);
    return {1'b0, k} + 3'd3;
  endfunction

  // weight/bias ROM with one-cycle read latency; datapath result chosen by address
  always @(posedge clk3) begin
    if (w_rd) begin
      w_data <= rom_w(w_addr);
      b_data <= rom_b(w_addr);
    end
  end
  assign nrn_out = seq[w_addr];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_seq(input logic [OB-1:0] a, b, c, d);
    seq[0] = a; seq[1] = b; seq[2] = c; seq[3] = d;
  endtask

  task automatic run_pass(input logic [IS-1:0] feat, input logic [NN*OB-1:0] exp_res,
                          input logic [AW-1:0] exp_idx, input logic [OB-1:0] exp_val,
                          input bit dbl_start);
    int dones = 0;
    int ph;
    int kk;
    logic [AW-1:0] ei;
    logic [OB-1:0] ev;
`ifdef LAYER1_SCHED_MAXIDX_EN
    ei = exp_idx; ev = exp_val;
`else
    ei = '0; ev = '0;
`endif
    @(negedge clk3);
    feat_in = feat;
    start   = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk3);
      if (done) dones++;
      if (c <= 16) begin
        ph = (c - 1) % 4;
        kk = (c - 1) / 4;
        chk("busy", 64'(busy), 64'd1);
        chk("w_rd", 64'(w_rd), 64'(ph == 0));
        chk("nrn_clr", 64'(nrn_clr), 64'(ph == 1));
        chk("w_addr", 64'(w_addr), 64'(kk));
        if (ph == 2) begin
          chk("weight_out", 64'(weight_out), 64'(rom_w(AW'(kk))));
          chk("bias_out", 64'(bias_out), 64'(rom_b(AW'(kk))));
          chk("feat_out", 64'(feat_out), 64'(feat));
        end
      end
      if (c == 17) begin
        chk("done", 64'(done), 64'd1);
        chk("result", 64'(result), 64'(exp_res));
        chk("max_idx", 64'(max_idx), 64'(ei));
        chk("max_val", 64'(max_val), 64'(ev));
      end
      if (c == 18) chk("idle_busy", 64'(busy), 64'd0);
      if (c == 20) chk("result_hold", 64'(result), 64'(exp_res));
      if (c == 1) start = 1'b0;
      if (c == 3) feat_in = ~feat;
      if (dbl_start && c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
    end
    chk("done_count", 64'(dones), 64'd1);
  endtask

  initial begin
    int dones;
    set_seq(4'd3, 4'd7, 4'd2, 4'd7);
    #2 reset2 = 1'b0;
    @(negedge clk3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_w_rd", 64'(w_rd), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    reset2 = 1'b1;

    run_pass(8'hA6, 16'h7273, 2'd1, 4'd7, 1'b0);
    run_pass(8'h3C, 16'h7273, 2'd1, 4'd7, 1'b1);
    set_seq(4'd5, 4'd5, 4'd1, 4'd0);
    run_pass(8'h81, 16'h0155, 2'd0, 4'd5, 1'b0);

    // abort in the STORE cycle of neuron 1
    set_seq(4'd3, 4'd7, 4'd2, 4'd7);
    dones = 0;
    @(negedge clk3);
    feat_in = 8'h5A;
    start   = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk3);
      if (done) dones++;
      if (c == 1) start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk3);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_result", 64'(result), 64'h0003);
    chk("abort_w_rd", 64'(w_rd), 64'd0);
    for (int c = 0; c < 12; c++) begin
      if (done) dones++;
      @(negedge clk3);
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_result_hold", 64'(result), 64'h0003);

    // asynchronous reset in cycle 9 of a pass
    @(negedge clk3);
    feat_in = 8'hC3;
    start   = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk3);
      if (c == 1) start = 1'b0;
    end
    reset2 = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_w_rd", 64'(w_rd), 64'd0);
    chk("mid_rst_nrn_clr", 64'(nrn_clr), 64'd0);
    chk("mid_rst_w_addr", 64'(w_addr), 64'd0);
    chk("mid_rst_feat_out", 64'(feat_out), 64'd0);
    chk("mid_rst_weight_out", 64'(weight_out), 64'd0);
    chk("mid_rst_bias_out", 64'(bias_out), 64'd0);
    chk("mid_rst_result", 64'(result), 64'd0);
    chk("mid_rst_max_idx", 64'(max_idx), 64'd0);
    chk("mid_rst_max_val", 64'(max_val), 64'd0);
    @(negedge clk3);
    reset2 = 1'b1;
    run_pass(8'h42, 16'h7273, 2'd1, 4'd7, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/layer1_sched.md
LAYER1_SCHED -- requirements
Module: layer1_sched

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 32: neurons time-multiplexed onto one layer-1 neuron datapath.
REQ-002 SHALL have parameter IMAGE_SIZE, default 121: feature count, 1 bit each.
REQ-003 SHALL have parameter WEIGHT_BIT, default 4: bits per signed weight.
REQ-004 SHALL have parameter OUTPUT_BIT, default 4: bits per neuron result.
REQ-005 SHALL have ports:
- clk3  in  1  single clock; all logic on the rising edge.
- reset2  in  1  asynchronous, active-low reset.
- start  in  1  request a layer pass; accepted only in IDLE.
- abort  in  1  synchronous abort of a pass in progress.
- feat_in  in  IMAGE_SIZE  input image, captured on accepted start.
- w_data  in  WEIGHT_BIT*IMAGE_SIZE  weight-ROM word, valid the cycle after w_rd.
- b_data  in  3  bias-ROM word, same timing as w_data.
- nrn_out  in  OUTPUT_BIT  neuron datapath result.
- w_rd  out  1  weight/bias ROM read strobe.
- w_addr  out  clog2(NUM_NEURONS)  ROM address = current neuron index k.
- feat_out  out  IMAGE_SIZE  registered features to the datapath.
- weight_out  out  WEIGHT_BIT*IMAGE_SIZE  registered weights to the datapath.
- bias_out  out  3  registered bias to the datapath.
- nrn_clr  out  1  active-high synchronous clear to the datapath.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on pass completion.
- result  out  NUM_NEURONS*OUTPUT_BIT  packed results; neuron k at bits [k*OUTPUT_BIT +: OUTPUT_BIT].
- max_idx  out  clog2(NUM_NEURONS)  argmax index (see Configuration).
- max_val  out  OUTPUT_BIT  argmax value (see Configuration).

Function
REQ-006 SHALL implement FSM states IDLE, FETCH, CLEAR, EVAL, STORE, DONE.
REQ-007 IDLE: start=1 SHALL capture feat_in into feat_out, clear result and k to 0, and go to FETCH.
REQ-008 FETCH: SHALL assert w_rd=1 with w_addr=k, then go to CLEAR.
REQ-009 CLEAR: SHALL latch w_data into weight_out and b_data into bias_out, assert nrn_clr=1, then go to EVAL.
REQ-010 EVAL: SHALL hold nrn_clr=0 and all datapath inputs stable for one cycle, then go to STORE.
REQ-011 STORE: SHALL write nrn_out into result slot k; if k==NUM_NEURONS-1, go to DONE; else increment k and go to FETCH.
REQ-012 DONE: SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-013 Latency SHALL be 4 cycles per neuron; with start sampled in cycle 0, done SHALL be high in cycle 4*NUM_NEURONS+1.
REQ-014 start SHALL be ignored in every state other than IDLE, including DONE.
REQ-015 abort=1 in any state other than IDLE/DONE SHALL go to IDLE next cycle with no done pulse and no STORE write that cycle; abort SHALL take priority over the STORE write.
REQ-016 result SHALL hold its value after done until the next accepted start; slots not yet written after an abort SHALL read 0.
REQ-017 feat_in changes while busy SHALL have no effect on feat_out.
REQ-018 w_rd and nrn_clr SHALL be low in IDLE, EVAL, STORE and DONE.

Reset
REQ-019 reset2=0 SHALL force IDLE at once and set k, busy, done, w_rd, nrn_clr, w_addr, feat_out, weight_out, bias_out, result, max_idx and max_val to 0, including mid-pass.
REQ-020 After reset2 is released, the block SHALL accept start on the first rising edge with start=1.

Configuration
REQ-021 With LAYER1_SCHED_MAXIDX_EN defined, a running max SHALL be kept: cleared to 0 on accepted start and updated in STORE when nrn_out > max_val (strict, so the lowest index wins ties); max_idx/max_val SHALL be final when done is high.
REQ-022 Without LAYER1_SCHED_MAXIDX_EN, max_idx and max_val SHALL be tied to 0 and no compare logic SHALL be built.

Verification (NUM_NEURONS=4)
REQ-023 Start pulse, ROM nrn_out sequence 3,7,2,7 -> done in cycle 17, result={7,2,7,3} (slot 3 down to 0), busy high in cycles 1-16.
REQ-024 Second start pulse in cycle 5 of a pass -> ignored; a single done in cycle 17.
REQ-025 abort in the STORE cycle of neuron 1 -> IDLE next cycle, no done, result slot 1 = 0, slot 0 retained.
REQ-026 reset2 low in cycle 9 -> all outputs 0 at once; start after release -> full pass with normal timing.
REQ-027 Check nrn_clr=1 and w_rd=1 in cycles 2 and 1 of every neuron respectively; weight_out equals the ROM word for address k during EVAL.
REQ-028 Build with LAYER1_SCHED_MAXIDX_EN, sequence 3,7,2,7 -> max_idx=1, max_val=7 at done; build without the macro -> both 0.
